// File: rtl/issue_group_sequencer_if.sv
// Decode-side bundle handshake and issue-side group handshake of the issue group sequencer.
// The sequencer takes the slave modport; decode/issue (or a bench) take the master modport.
interface issue_group_sequencer_if #(
  parameter int NUM_WIDTH = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_WIDTH-1:0] in_inst_valid;
  logic [NUM_WIDTH-1:0] in_branch;
  logic [NUM_WIDTH-1:0] in_mem_read;
  logic [NUM_WIDTH-1:0] in_mem_write;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [NUM_WIDTH-1:0] issue_slot_mask;
  logic [NUM_WIDTH-1:0] issue_branch;
  logic [NUM_WIDTH-1:0] issue_mem_read;
  logic [NUM_WIDTH-1:0] issue_mem_write;
  logic                 flush;

  modport master (
    output in_valid, in_inst_valid, in_branch, in_mem_read, in_mem_write,
    output issue_ready, flush,
    input  in_ready, issue_valid, issue_slot_mask,
    input  issue_branch, issue_mem_read, issue_mem_write
  );

  modport slave (
    input  in_valid, in_inst_valid, in_branch, in_mem_read, in_mem_write,
    input  issue_ready, flush,
    output in_ready, issue_valid, issue_slot_mask,
    output issue_branch, issue_mem_read, issue_mem_write
  );
endinterface

// File: rtl/issue_group_sequencer.sv
// Holds one decoded bundle and issues it as in-order groups: each group carries at most
// one memory op and ends at the first branch. Decode is stalled until the bundle drains.
module issue_group_sequencer #(
  parameter int NUM_WIDTH = 3,
  parameter int COUNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  issue_group_sequencer_if.slave bus,
  output logic [COUNT_W-1:0]     split_count
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t               state_reg;
  logic [NUM_WIDTH-1:0] pending_reg;
  logic [NUM_WIDTH-1:0] branch_reg;
  logic [NUM_WIDTH-1:0] mem_read_reg;
  logic [NUM_WIDTH-1:0] mem_write_reg;
  logic                 split_flag_reg;
  logic [COUNT_W-1:0]   split_count_reg;

  logic [NUM_WIDTH-1:0] stop_vec;
  logic [NUM_WIDTH-1:0] blocked_vec;
  logic [NUM_WIDTH-1:0] group_vec;
  logic [NUM_WIDTH-1:0] remaining_vec;
  logic                 issue_valid;
  logic                 fire;
  logic                 last_fire;
  logic                 in_ready;
  logic                 accept;

  // blocked_vec[i] is set once any older pending slot has closed the group.
  assign blocked_vec[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < NUM_WIDTH; gi++) begin : g_slot
      assign stop_vec[gi]  = pending_reg[gi] &
                             (branch_reg[gi] | mem_read_reg[gi] | mem_write_reg[gi]);
      assign group_vec[gi] = pending_reg[gi] & ~blocked_vec[gi];
      if (gi < NUM_WIDTH - 1) begin : g_chain
        assign blocked_vec[gi+1] = blocked_vec[gi] | stop_vec[gi];
      end
    end
  endgenerate

  assign remaining_vec = pending_reg & ~group_vec;
  assign issue_valid   = (state_reg == S_HOLD) && !bus.flush;
  assign fire          = issue_valid && bus.issue_ready;
  assign last_fire     = fire && (remaining_vec == '0);
  // Accepting alongside the final group lets a new bundle follow with no bubble.
  assign in_ready      = !bus.flush && ((state_reg == S_EMPTY) || last_fire);
  assign accept        = bus.in_valid && in_ready;

  assign bus.in_ready        = in_ready;
  assign bus.issue_valid     = issue_valid;
  assign bus.issue_slot_mask = issue_valid ? group_vec : '0;
  assign bus.issue_branch    = branch_reg;
  assign bus.issue_mem_read  = mem_read_reg;
  assign bus.issue_mem_write = mem_write_reg;
  assign split_count         = split_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_EMPTY;
      pending_reg     <= '0;
      branch_reg      <= '0;
      mem_read_reg    <= '0;
      mem_write_reg   <= '0;
      split_flag_reg  <= 1'b0;
      split_count_reg <= '0;
    end else if (bus.flush) begin
      state_reg      <= S_EMPTY;
      pending_reg    <= '0;
      split_flag_reg <= 1'b0;
    end else if (accept) begin
      pending_reg    <= bus.in_inst_valid;
      branch_reg     <= bus.in_branch;
      mem_read_reg   <= bus.in_mem_read;
      mem_write_reg  <= bus.in_mem_write;
      split_flag_reg <= 1'b0;
      state_reg      <= (bus.in_inst_valid != '0) ? S_HOLD : S_EMPTY;
    end else if (fire) begin
      pending_reg <= remaining_vec;
      state_reg   <= (remaining_vec != '0) ? S_HOLD : S_EMPTY;
      // Count each bundle once, when its first non-final group leaves.
      if ((remaining_vec != '0) && !split_flag_reg) begin
        split_flag_reg <= 1'b1;
        if (split_count_reg != {COUNT_W{1'b1}}) begin
          split_count_reg <= split_count_reg + COUNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_group_sequencer.sv
// Directed bench for issue_group_sequencer: expected groups are queued when a bundle is
// accepted and popped as the sequencer issues them; a narrow-counter copy shows saturation.
module tb_issue_group_sequencer;

  logic       clk;
  logic       rst_n;
  logic [2:0] split_count_small;
  logic [15:0] split_count;

  issue_group_sequencer_if #(.NUM_WIDTH(3)) bus ();
  issue_group_sequencer_if #(.NUM_WIDTH(3)) bus_sat ();

  assign bus_sat.in_valid      = bus.in_valid;
  assign bus_sat.in_inst_valid = bus.in_inst_valid;
  assign bus_sat.in_branch     = bus.in_branch;
  assign bus_sat.in_mem_read   = bus.in_mem_read;
  assign bus_sat.in_mem_write  = bus.in_mem_write;
  assign bus_sat.issue_ready   = bus.issue_ready;
  assign bus_sat.flush         = bus.flush;

  issue_group_sequencer #(.NUM_WIDTH(3), .COUNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .split_count (split_count)
  );

  issue_group_sequencer #(.NUM_WIDTH(3), .COUNT_W(3)) dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_sat),
    .split_count (split_count_small)
  );

  typedef struct {
    logic [2:0] mask;
    logic [2:0] br;
    logic [2:0] mr;
    logic [2:0] mw;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   exp_split  = 0;
  int   exp_small  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference grouping: walk pending oldest-first, closing the group at a branch/memory op.
  task automatic push_bundle(input logic [2:0] v, input logic [2:0] b,
                             input logic [2:0] r, input logic [2:0] w);
    logic [2:0] pend;
    logic [2:0] grp;
    int         ng;
    exp_t       e;
    pend = v;
    ng   = 0;
    while (pend != 3'b000) begin
      grp = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (pend[i]) begin
          grp[i] = 1'b1;
          if (b[i] || r[i] || w[i]) break;
        end
      end
      e.mask = grp; e.br = b; e.mr = r; e.mw = w;
      sb.push_back(e);
      pend = pend & ~grp;
      ng++;
    end
    if (ng > 1) begin
      exp_split++;
      exp_small = (exp_small == 7) ? 7 : exp_small + 1;
    end
  endtask

  task automatic send_bundle(input logic [2:0] v, input logic [2:0] b,
                             input logic [2:0] r, input logic [2:0] w);
    int n;
    n = 0;
    bus.in_valid      = 1'b1;
    bus.in_inst_valid = v;
    bus.in_branch     = b;
    bus.in_mem_read   = r;
    bus.in_mem_write  = w;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 50);
    check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    push_bundle(v, b, r, w);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", sb.size(), 32'd0);
  endtask

  // Group scoreboard: every presented group is compared; consumed groups are popped.
  always @(negedge clk) begin
    if (rst_n && !bus.flush) begin
      if (sb.size() > 0) check("issue_valid", {31'd0, bus.issue_valid}, 32'd1);
      if (!bus.issue_valid) begin
        check("idle_mask", {29'd0, bus.issue_slot_mask}, 32'd0);
      end else begin
        check("spurious_group", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
          check("group_mask", {29'd0, bus.issue_slot_mask}, {29'd0, sb[0].mask});
          check("group_branch", {29'd0, bus.issue_branch}, {29'd0, sb[0].br});
          check("group_mem_read", {29'd0, bus.issue_mem_read}, {29'd0, sb[0].mr});
          check("group_mem_write", {29'd0, bus.issue_mem_write}, {29'd0, sb[0].mw});
          if (bus.issue_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_issue_valid", {31'd0, bus.issue_valid}, 32'd0);
    check("rst_mask", {29'd0, bus.issue_slot_mask}, 32'd0);
    check("rst_branch", {29'd0, bus.issue_branch}, 32'd0);
    check("rst_mem_read", {29'd0, bus.issue_mem_read}, 32'd0);
    check("rst_mem_write", {29'd0, bus.issue_mem_write}, 32'd0);
    check("rst_split_count", {16'd0, split_count}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_inst_valid = 3'b000;
    bus.in_branch     = 3'b000;
    bus.in_mem_read   = 3'b000;
    bus.in_mem_write  = 3'b000;
    bus.issue_ready   = 1'b1;
    bus.flush         = 1'b0;
    #3;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Memory op in slot 1: groups {0,1} then {2}, in_ready rises with the final group.
    send_bundle(3'b111, 3'b000, 3'b010, 3'b000);
    @(negedge clk);
    check("t1_in_ready_first", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t1_in_ready_final", {31'd0, bus.in_ready}, 32'd1);
    drain();
    check("t1_split_count", {16'd0, split_count}, exp_split);

    // Branch at slot 0, store at slot 2: groups {0} then {1,2}.
    send_bundle(3'b111, 3'b001, 3'b000, 3'b100);
    drain();
    check("t2_split_count", {16'd0, split_count}, exp_split);

    // Three plain bundles back to back: one full group per cycle, no bubble.
    send_bundle(3'b111, 3'b000, 3'b000, 3'b000);
    send_bundle(3'b111, 3'b000, 3'b000, 3'b000);
    send_bundle(3'b111, 3'b000, 3'b000, 3'b000);
    drain();
    check("t3_split_count", {16'd0, split_count}, exp_split);

    // Holes: valid=101 with memory ops in slots 0 and 2, then an empty bundle.
    send_bundle(3'b101, 3'b000, 3'b001, 3'b100);
    send_bundle(3'b000, 3'b010, 3'b010, 3'b010);
    repeat (3) @(posedge clk);
    #1;
    drain();
    check("t4_split_count", {16'd0, split_count}, exp_split);

    // Backpressure for three cycles, then flush racing a new bundle.
    bus.issue_ready = 1'b0;
    send_bundle(3'b111, 3'b000, 3'b010, 3'b000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    bus.flush         = 1'b1;
    bus.in_valid      = 1'b1;
    bus.in_inst_valid = 3'b111;
    bus.in_branch     = 3'b000;
    bus.in_mem_read   = 3'b000;
    bus.in_mem_write  = 3'b000;
    @(negedge clk);
    check("flush_issue_valid", {31'd0, bus.issue_valid}, 32'd0);
    check("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    sb.delete();
    exp_split       = exp_split - 1;
    exp_small       = exp_small - 1;
    bus.flush       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.issue_ready = 1'b1;
    @(negedge clk);
    check("post_flush_issue_valid", {31'd0, bus.issue_valid}, 32'd0);
    check("post_flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t5_split_count", {16'd0, split_count}, exp_split);

    // Enough split bundles to saturate the 3-bit counter copy.
    for (int k = 0; k < 10; k++) begin
      send_bundle(3'b111, 3'b000, 3'b001, 3'b000);
    end
    drain();
    check("sat_split_count", {16'd0, split_count}, exp_split);
    check("sat_small_count", {29'd0, split_count_small}, exp_small);
    check("sat_small_max", {29'd0, split_count_small}, 32'd7);

    // Asynchronous reset in the middle of a held bundle.
    bus.issue_ready = 1'b0;
    send_bundle(3'b111, 3'b010, 3'b000, 3'b100);
    #2;
    rst_n = 1'b0;
    sb.delete();
    exp_split = 0;
    exp_small = 0;
    #1;
    check_reset_outputs();
    check("rst_small_count", {29'd0, split_count_small}, 32'd0);
    @(posedge clk);
    #1;
    rst_n           = 1'b1;
    bus.issue_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_split_count", {16'd0, split_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
